// File: rtl/adc_test_pkg.sv
// adc_test_pkg: shared FSM state encoding and overrun counter width for adc_playback_gen
package adc_test_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, READ, CAPTURE, OUT, DONE} state_t;
  localparam int OVR_W = 16;
endpackage

// File: rtl/tick_div.sv
// tick_div: sample-period divider; counts 0..CLK_DIV-1 while enabled, held at zero otherwise
module tick_div #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int W = ($clog2(CLK_DIV) > 1) ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || !en) cnt <= '0;
    else cnt <= (cnt == W'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
  assign tick = en && cnt == W'(CLK_DIV - 1);
endmodule

// File: rtl/adc_playback_gen.sv
// adc_playback_gen: replays interleaved multi-channel ADC captures from sample memory as a valid/ready stream.
// Define ADC_PLAYBACK_OVR_CNT_EN to add the ovr_cnt lost-sample-period counter.
module adc_playback_gen
  import adc_test_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 31000,
  parameter int DATA_W = 12,
  parameter int CLK_DIV = 8,
  localparam int AW = $clog2(NUM_CH * DEPTH),
  localparam int CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CW-1:0]     m_ch,
  output logic              m_last,
  output logic              busy,
  output logic              done
`ifdef ADC_PLAYBACK_OVR_CNT_EN
  ,
  output logic [OVR_W-1:0]  ovr_cnt
`endif
);
  localparam int IW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [CW-1:0] ch;
  logic tick, go, hs, last_ch, last_idx;
  tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .en(busy),
    .tick(tick)
  );
  assign go = start && !stop;
  assign hs = state == OUT && m_ready;
  assign last_ch = ch == CW'(NUM_CH - 1);
  assign last_idx = idx == IW'(DEPTH - 1);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = go ? WAIT_TICK : IDLE;
      WAIT_TICK: nxt = tick ? READ : WAIT_TICK;
      READ:      nxt = CAPTURE;
      CAPTURE:   nxt = OUT;
      OUT:       nxt = !hs ? OUT : !last_ch ? READ : (!last_idx || loop_mode) ? WAIT_TICK : DONE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    m_valid = state == OUT;
    rd_en = state == READ;
    rd_addr = rd_en ? AW'(ch * DEPTH + idx) : '0;
  end
  // ch/idx advance on every accepted beat; a stop in the same cycle is harmless since start re-clears them
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx <= '0;
      ch <= '0;
      m_data <= '0;
      m_ch <= '0;
      m_last <= 1'b0;
    end else if (state == IDLE && go) begin
      idx <= '0;
      ch <= '0;
    end else if (state == CAPTURE) begin
      m_data <= rd_data;
      m_ch <= ch;
      m_last <= last_ch && last_idx;
    end else if (hs) begin
      ch <= last_ch ? '0 : ch + 1'b1;
      idx <= !last_ch ? idx : last_idx ? '0 : idx + 1'b1;
    end
`ifdef ADC_PLAYBACK_OVR_CNT_EN
  // a tick seen outside WAIT_TICK is a sample period the stream could not keep up with
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && go)) ovr_cnt <= '0;
    else if (tick && state != WAIT_TICK && ovr_cnt != '1) ovr_cnt <= ovr_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_adc_playback_gen.sv
// tb_adc_playback_gen: randomized self-checking bench with a transaction-level playback model
module tb_adc_playback_gen;
  localparam int NC = 2, DP = 4, CD = 8, DW = 12, AW = 3, CW = 1;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, loop_mode = 0, m_ready = 1;
  logic rd_en, m_valid, m_last, busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;
  logic [CW-1:0] m_ch;
`ifdef ADC_PLAYBACK_OVR_CNT_EN
  logic [15:0] ovr_cnt;
`endif
  logic [DW-1:0] mem [NC*DP];
  int total = 0, bad = 0;
  int cyc, start_cyc, eidx, ech, ticks, reads, nbeats, nlast, ndone, nrd;
  bit act, pend, due, hs, plast, p_rstn, p_stop, p_go, p_fin, p_done, p_stall;
  logic [DW-1:0] pdata, pm_data;
  logic [CW-1:0] pch, pm_ch;
  logic pm_last;
  int addr_log[256];
  int last_at[16];
  int exp_a[8] = '{0, 4, 1, 5, 2, 6, 3, 7};

  always #5 clk = ~clk;

  adc_playback_gen #(.NUM_CH(NC), .DEPTH(DP), .DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_mode(loop_mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
    .busy(busy), .done(done)
`ifdef ADC_PLAYBACK_OVR_CNT_EN
    , .ovr_cnt(ovr_cnt)
`endif
  );

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
    end
  endtask

  // Transaction-level model: expected read order, beat contents, done/busy windows and tick grid
  initial forever begin
    @(negedge clk);
    cyc++;
    due = 0;
    if (!p_rstn) begin
      act = 0;
      pend = 0;
      chk("reset_outputs", {rd_en, rd_addr, m_valid, m_data, m_ch, m_last, busy, done}, 0);
    end else if (p_stop) act = 0;
    else if (p_go) begin
      act = 1;
      start_cyc = cyc;
      eidx = 0;
      ech = 0;
      pend = 0;
      ticks = 0;
      reads = 0;
    end else if (p_fin) due = 1;
    else if (p_done) act = 0;
    chk("busy", busy, act);
    chk("done", done, due);
    if (!act) chk("idle_quiet", {rd_en, m_valid}, 0);
    if (p_stall) chk("stall_hold", {m_valid, m_data, m_ch, m_last}, {1'b1, pm_data, pm_ch, pm_last});
    if (rd_en) begin
      chk("rd_addr", rd_addr, ech * DP + eidx);
      chk("rd_once", pend, 0);
      if (ech == 0) begin
        chk("tick_phase", (cyc - start_cyc) % CD, 0);
        reads++;
      end
      if (nrd < 256) addr_log[nrd] = int'(rd_addr);
      nrd++;
      pend = 1;
      pdata = mem[ech * DP + eidx];
      pch = CW'(ech);
      plast = ech == NC - 1 && eidx == DP - 1;
    end
    if (m_valid) begin
      chk("valid_pending", pend, 1);
      chk("beat", {m_data, m_ch, m_last}, {pdata, pch, plast});
    end
    hs = m_valid && m_ready && !stop && rst_n;
    p_fin = 0;
    if (hs) begin
      pend = 0;
      nbeats++;
      if (m_last && nlast < 16) last_at[nlast] = nbeats;
      if (m_last) nlast++;
      if (ech < NC - 1) ech++;
      else if (eidx < DP - 1) begin
        eidx++;
        ech = 0;
      end else begin
        eidx = 0;
        ech = 0;
        p_fin = !loop_mode;
      end
    end
    if (done) ndone++;
`ifdef ADC_PLAYBACK_OVR_CNT_EN
    if (act) chk("ovr_cnt", ovr_cnt, ticks - reads);
    if (act && (cyc - start_cyc) % CD == CD - 1) ticks++;
`endif
    p_done = due;
    p_rstn = rst_n;
    p_stop = stop;
    p_go = !act && start && !stop && rst_n;
    p_stall = m_valid && !m_ready && !stop && rst_n;
    pm_data = m_data;
    pm_ch = m_ch;
    pm_last = m_last;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 2000) begin
      step(1);
      k++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic wait_beats(input int n, input string nm);
    int k = 0;
    while (nbeats < n && k < 2000) begin
      step(1);
      k++;
    end
    chk(nm, nbeats >= n, 1);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!m_valid && k < 100) begin
      step(1);
      k++;
    end
    chk(nm, m_valid, 1);
  endtask

  task automatic clear_log;
    nbeats = 0;
    nlast = 0;
    ndone = 0;
    nrd = 0;
  endtask

  task automatic kick;
    start = 1;
    step(1);
    start = 0;
  endtask

  initial begin
    for (int i = 0; i < NC * DP; i++) mem[i] = DW'($urandom);
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid_rd", {m_valid, rd_en}, 0);
    rst_n = 1;
    step(1);
    // one-shot, always ready
    clear_log();
    kick();
    wait_idle("A_finish");
    chk("A_beats", nbeats, 8);
    chk("A_last_count", nlast, 1);
    chk("A_last_beat", last_at[0], 8);
    chk("A_done_pulses", ndone, 1);
    for (int i = 0; i < 8; i++) chk("A_addr_order", addr_log[i], exp_a[i]);
`ifdef ADC_PLAYBACK_OVR_CNT_EN
    chk("A_ovr", ovr_cnt, 0);
`endif
    // loop mode, 20 beats
    clear_log();
    loop_mode = 1;
    kick();
    wait_beats(20, "B_beats");
    chk("B_last_first", last_at[0], 8);
    chk("B_last_second", last_at[1], 16);
    chk("B_wrap_addr", addr_log[8], 0);
    chk("B_no_done", ndone, 0);
    stop = 1;
    step(1);
    stop = 0;
    chk("B_stopped", busy, 0);
    loop_mode = 0;
    step(2);
    // stall during beat 3
    clear_log();
    kick();
    wait_beats(2, "C_two_beats");
    m_ready = 0;
    wait_valid("C_beat3_valid");
    step(5);
    m_ready = 1;
    wait_idle("C_finish");
    chk("C_beats", nbeats, 8);
    chk("C_reads", nrd, 8);
    chk("C_done_pulses", ndone, 1);
`ifdef ADC_PLAYBACK_OVR_CNT_EN
    chk("C_ovr", ovr_cnt, 1);
`endif
    // stop during OUT, then start+stop in IDLE
    clear_log();
    kick();
    wait_valid("D_valid");
    stop = 1;
    step(1);
    stop = 0;
    chk("D_stop_out", {m_valid, done, busy}, 0);
    start = 1;
    stop = 1;
    step(1);
    start = 0;
    stop = 0;
    chk("D_start_stop", busy, 0);
    step(2);
    chk("D_still_idle", busy, 0);
    // reset mid-beat, then restart
    clear_log();
    kick();
    wait_beats(3, "E_beats");
    wait_valid("E_valid");
    rst_n = 0;
    step(1);
    chk("E_rst_out", {rd_en, rd_addr, m_valid, m_data, m_ch, m_last, busy, done}, 0);
`ifdef ADC_PLAYBACK_OVR_CNT_EN
    chk("E_rst_ovr", ovr_cnt, 0);
`endif
    rst_n = 1;
    step(1);
    clear_log();
    kick();
    wait_idle("E_restart_finish");
    chk("E_first_addr", addr_log[0], 0);
    chk("E_beats", nbeats, 8);
    // randomized runs
    for (int r = 0; r < 12; r++) begin
      clear_log();
      loop_mode = 1'($urandom_range(0, 1));
      kick();
      for (int k = 0; k < 1500 && busy; k++) begin
        m_ready = $urandom_range(0, 3) != 0;
        stop = $urandom_range(0, 299) == 0;
        if (nbeats > 24) loop_mode = 0;
`ifndef ADC_PLAYBACK_OVR_CNT_EN
        start = $urandom_range(0, 49) == 0;
`endif
        step(1);
      end
      start = 0;
      stop = 0;
      if (busy) begin
        stop = 1;
        step(1);
        stop = 0;
      end
      chk("R_idle", busy, 0);
      m_ready = 1;
      step(2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
